// File: rtl/writeback_stage_pkg.sv
// ---------------------------------------------------------------------------
// writeback_stage_pkg
// Shared MIPS32 definitions used by the writeback stage and the load
// extraction helper:
//   - wb_sel_e    : result-source selector encodings (ALU / MEM / LINK)
//   - load_type_e : load width/extension encodings
//   - REG_W       : GPR number width
// ---------------------------------------------------------------------------
package writeback_stage_pkg;

    localparam int REG_W = 5;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_MEM  = 2'b01,
        WB_LINK = 2'b10,
        WB_RSVD = 2'b11   // behaves as ALU
    } wb_sel_e;

    typedef enum logic [2:0] {
        LD_LW  = 3'b000,
        LD_LH  = 3'b001,
        LD_LHU = 3'b010,
        LD_LB  = 3'b011,
        LD_LBU = 3'b100
    } load_type_e;

endpackage

// File: rtl/writeback_stage_load_extract.sv
// ---------------------------------------------------------------------------
// writeback_stage_load_extract
// Purely combinational big-endian sub-word load extraction (byte 0 is
// bits [31:24]). Also shared with the cache refill path.
// Ports:
//   mem_data  : raw aligned memory word
//   addr_lo   : effective address bits [1:0]
//   load_type : load_type_e encoding
//   data      : extracted, sign/zero-extended value
//   err       : misaligned access or reserved load type
// ---------------------------------------------------------------------------
module writeback_stage_load_extract
    import writeback_stage_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] mem_data,
    input  logic [1:0]        addr_lo,
    input  logic [2:0]        load_type,
    output logic [DATA_W-1:0] data,
    output logic              err
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Select the addressed byte and halfword from the big-endian word.
    always_comb begin
        byte_s = 8'h00;
        case (addr_lo)
            2'b00:   byte_s = mem_data[31:24];
            2'b01:   byte_s = mem_data[23:16];
            2'b10:   byte_s = mem_data[15:8];
            2'b11:   byte_s = mem_data[7:0];
            default: byte_s = 8'h00;
        endcase
        half_s = addr_lo[1] ? mem_data[15:0] : mem_data[31:16];
    end

    // Extend the selected field and flag misaligned or reserved loads.
    always_comb begin
        data = mem_data;
        err  = 1'b0;
        case (load_type)
            LD_LW: begin
                data = mem_data;
                err  = (addr_lo != 2'b00);
            end
            LD_LH: begin
                data = {{(DATA_W-16){half_s[15]}}, half_s};
                err  = addr_lo[0];
            end
            LD_LHU: begin
                data = {{(DATA_W-16){1'b0}}, half_s};
                err  = addr_lo[0];
            end
            LD_LB: begin
                data = {{(DATA_W-8){byte_s[7]}}, byte_s};
                err  = 1'b0;
            end
            LD_LBU: begin
                data = {{(DATA_W-8){1'b0}}, byte_s};
                err  = 1'b0;
            end
            default: begin
                data = mem_data;
                err  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// ---------------------------------------------------------------------------
// writeback_stage
// MEM/WB pipeline register plus writeback logic of the 5-stage MIPS32 core.
// Drives the register-file write port, the hazard-unit forwarding source and
// a retired-instruction counter.
// Ports:
//   clk, reset (async, active-low)
//   stall         : hold stage contents
//   flush         : load a bubble (wins over stall)
//   in_*          : memory-stage instruction fields
//   reg_write_en  : register-file write enable (never for $0 or on addr_err)
//   wb_dest       : register-file write address (always driven)
//   write_data    : register-file write data
//   fwd_valid     : wb_dest/write_data are a valid forwarding source
//   addr_err      : resident load is misaligned or of reserved type
//   retire_count  : retired-instruction count, wraps modulo 2^CNT_W
// ---------------------------------------------------------------------------
module writeback_stage
    import writeback_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    input  logic              in_reg_write,
    input  logic [REG_W-1:0]  in_dest,
    input  logic [1:0]        in_wb_sel,
    input  logic [2:0]        in_load_type,
    input  logic [1:0]        in_addr_lo,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [DATA_W-1:0] in_mem_data,
    input  logic [DATA_W-1:0] in_pc_plus8,
    output logic              reg_write_en,
    output logic [REG_W-1:0]  wb_dest,
    output logic [DATA_W-1:0] write_data,
    output logic              fwd_valid,
    output logic              addr_err,
    output logic [CNT_W-1:0]  retire_count
);

    logic              valid_r;
    logic              reg_write_r;
    logic [REG_W-1:0]  dest_r;
    logic [1:0]        wb_sel_r;
    logic [2:0]        load_type_r;
    logic [1:0]        addr_lo_r;
    logic [DATA_W-1:0] alu_r;
    logic [DATA_W-1:0] mem_r;
    logic [DATA_W-1:0] pc8_r;
    logic [CNT_W-1:0]  cnt_r;

    logic [DATA_W-1:0] load_data_s;
    logic              load_err_s;
    logic              addr_err_s;
    logic              wr_en_s;
    logic              advance_s;
    logic [DATA_W-1:0] wdata_s;

    writeback_stage_load_extract #(
        .DATA_W (DATA_W)
    ) u_load_extract (
        .mem_data  (mem_r),
        .addr_lo   (addr_lo_r),
        .load_type (load_type_r),
        .data      (load_data_s),
        .err       (load_err_s)
    );

    // Stage register: flush loads a bubble, stall holds, otherwise capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_r     <= 1'b0;
            reg_write_r <= 1'b0;
            dest_r      <= {REG_W{1'b0}};
            wb_sel_r    <= 2'b00;
            load_type_r <= 3'b000;
            addr_lo_r   <= 2'b00;
            alu_r       <= {DATA_W{1'b0}};
            mem_r       <= {DATA_W{1'b0}};
            pc8_r       <= {DATA_W{1'b0}};
        end else if (flush) begin
            valid_r <= 1'b0;
        end else if (!stall) begin
            valid_r     <= in_valid;
            reg_write_r <= in_reg_write;
            dest_r      <= in_dest;
            wb_sel_r    <= in_wb_sel;
            load_type_r <= in_load_type;
            addr_lo_r   <= in_addr_lo;
            alu_r       <= in_alu_result;
            mem_r       <= in_mem_data;
            pc8_r       <= in_pc_plus8;
        end else begin
            valid_r <= valid_r;
        end
    end

    // The resident entry leaves the stage whenever it is replaced.
    assign advance_s = flush | ~stall;

    // Retire counter: counts valid, error-free entries as they leave.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (advance_s && valid_r && !addr_err_s) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Result source selection; the reserved selector falls back to ALU.
    always_comb begin
        wdata_s = alu_r;
        case (wb_sel_r)
            WB_ALU:  wdata_s = alu_r;
            WB_MEM:  wdata_s = load_data_s;
            WB_LINK: wdata_s = pc8_r;
            default: wdata_s = alu_r;
        endcase
    end

    assign addr_err_s = valid_r & (wb_sel_r == WB_MEM) & load_err_s;
    assign wr_en_s    = valid_r & reg_write_r & (dest_r != {REG_W{1'b0}}) & ~addr_err_s;

    assign reg_write_en = wr_en_s;
    assign fwd_valid    = wr_en_s;
    assign wb_dest      = dest_r;
    assign write_data   = wdata_s;
    assign addr_err     = addr_err_s;
    assign retire_count = cnt_r;

endmodule

// File: tb/tb_writeback_stage.sv
// ---------------------------------------------------------------------------
// tb_writeback_stage
// Directed self-checking bench for writeback_stage, built with CNT_W=4 so the
// retire counter wrap can be exercised quickly.
// ---------------------------------------------------------------------------
module tb_writeback_stage;
    import writeback_stage_pkg::*;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        in_valid;
    logic        in_reg_write;
    logic [4:0]  in_dest;
    logic [1:0]  in_wb_sel;
    logic [2:0]  in_load_type;
    logic [1:0]  in_addr_lo;
    logic [31:0] in_alu_result;
    logic [31:0] in_mem_data;
    logic [31:0] in_pc_plus8;
    logic        reg_write_en;
    logic [4:0]  wb_dest;
    logic [31:0] write_data;
    logic        fwd_valid;
    logic        addr_err;
    logic [3:0]  retire_count;

    int n_checks = 0;
    int n_fail   = 0;

    writeback_stage #(
        .DATA_W (32),
        .CNT_W  (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_reg_write  (in_reg_write),
        .in_dest       (in_dest),
        .in_wb_sel     (in_wb_sel),
        .in_load_type  (in_load_type),
        .in_addr_lo    (in_addr_lo),
        .in_alu_result (in_alu_result),
        .in_mem_data   (in_mem_data),
        .in_pc_plus8   (in_pc_plus8),
        .reg_write_en  (reg_write_en),
        .wb_dest       (wb_dest),
        .write_data    (write_data),
        .fwd_valid     (fwd_valid),
        .addr_err      (addr_err),
        .retire_count  (retire_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic rw, input logic [4:0] d,
                         input logic [1:0] sel, input logic [2:0] lt,
                         input logic [1:0] alo, input logic [31:0] alu,
                         input logic [31:0] mem, input logic [31:0] pc8);
        in_valid      = v;
        in_reg_write  = rw;
        in_dest       = d;
        in_wb_sel     = sel;
        in_load_type  = lt;
        in_addr_lo    = alo;
        in_alu_result = alu;
        in_mem_data   = mem;
        in_pc_plus8   = pc8;
    endtask

    initial begin
        reset = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        drive(1'b0, 1'b0, 5'd0, 2'b00, 3'b000, 2'b00, 32'd0, 32'd0, 32'd0);

        // Reset held with random inputs
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 5'($urandom), 2'($urandom), 3'($urandom),
                  2'($urandom), 32'($urandom), 32'($urandom), 32'($urandom));
            tick();
        end
        check("rst_wen",   32'(reg_write_en), 32'd0);
        check("rst_cnt",   32'(retire_count), 32'd0);
        check("rst_fwd",   32'(fwd_valid),    32'd0);
        check("rst_err",   32'(addr_err),     32'd0);
        check("rst_wdata", write_data,        32'd0);
        check("rst_dest",  32'(wb_dest),      32'd0);

        // Release reset, ALU write to $5
        reset = 1'b1;
        drive(1'b1, 1'b1, 5'd5, WB_ALU, LD_LW, 2'b00, 32'h12345678, 32'd0, 32'd0);
        tick();
        check("alu_wen",   32'(reg_write_en), 32'd1);
        check("alu_fwd",   32'(fwd_valid),    32'd1);
        check("alu_dest",  32'(wb_dest),      32'd5);
        check("alu_wdata", write_data,        32'h12345678);
        check("alu_cnt0",  32'(retire_count), 32'd0);

        // Sub-word loads from 0x80FF7F01
        drive(1'b1, 1'b1, 5'd6, WB_MEM, LD_LB, 2'd0, 32'd0, 32'h80FF7F01, 32'd0);
        tick();
        check("lb_cnt",   32'(retire_count), 32'd1);
        check("lb_data",  write_data,        32'hFFFFFF80);
        check("lb_wen",   32'(reg_write_en), 32'd1);
        check("lb_dest",  32'(wb_dest),      32'd6);

        drive(1'b1, 1'b1, 5'd7, WB_MEM, LD_LBU, 2'd1, 32'd0, 32'h80FF7F01, 32'd0);
        tick();
        check("lbu_data", write_data,        32'h000000FF);
        check("lbu_cnt",  32'(retire_count), 32'd2);

        drive(1'b1, 1'b1, 5'd8, WB_MEM, LD_LH, 2'd2, 32'd0, 32'h80FF7F01, 32'd0);
        tick();
        check("lh_data",  write_data,        32'h00007F01);
        check("lh_err",   32'(addr_err),     32'd0);
        check("lh_cnt",   32'(retire_count), 32'd3);

        drive(1'b1, 1'b1, 5'd9, WB_MEM, LD_LHU, 2'd0, 32'd0, 32'h80FF7F01, 32'd0);
        tick();
        check("lhu_data", write_data,        32'h000080FF);
        check("lhu_cnt",  32'(retire_count), 32'd4);

        // Misaligned LW, then misaligned LH
        drive(1'b1, 1'b1, 5'd10, WB_MEM, LD_LW, 2'd2, 32'd0, 32'h80FF7F01, 32'd0);
        tick();
        check("lw_err",   32'(addr_err),     32'd1);
        check("lw_wen",   32'(reg_write_en), 32'd0);
        check("lw_fwd",   32'(fwd_valid),    32'd0);
        check("lw_cnt",   32'(retire_count), 32'd5);

        drive(1'b1, 1'b1, 5'd11, WB_MEM, LD_LH, 2'd1, 32'd0, 32'h80FF7F01, 32'd0);
        tick();
        check("lh1_err",  32'(addr_err),     32'd1);
        check("lh1_wen",  32'(reg_write_en), 32'd0);
        check("lh1_cnt",  32'(retire_count), 32'd5);

        // Write to $0: suppressed but counted
        drive(1'b1, 1'b1, 5'd0, WB_ALU, LD_LW, 2'd0, 32'hCAFEF00D, 32'd0, 32'd0);
        tick();
        check("r0_wen",   32'(reg_write_en), 32'd0);
        check("r0_err",   32'(addr_err),     32'd0);
        check("r0_cnt",   32'(retire_count), 32'd5);

        // LINK to $31 (ALU value differs so the selector is observable)
        drive(1'b1, 1'b1, 5'd31, WB_LINK, LD_LW, 2'd0, 32'h0BADBEEF, 32'd0, 32'h00400010);
        tick();
        check("lnk_data", write_data,        32'h00400010);
        check("lnk_wen",  32'(reg_write_en), 32'd1);
        check("lnk_dest", 32'(wb_dest),      32'd31);
        check("lnk_cnt",  32'(retire_count), 32'd6);

        // Stall three cycles with different inputs presented
        stall = 1'b1;
        drive(1'b1, 1'b1, 5'd7, WB_ALU, LD_LW, 2'd0, 32'hDEADBEEF, 32'd0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stl_data", write_data,        32'h00400010);
            check("stl_dest", 32'(wb_dest),      32'd31);
            check("stl_cnt",  32'(retire_count), 32'd6);
        end

        // Flush with new input: bubble loaded, old entry counted once
        stall = 1'b0;
        flush = 1'b1;
        tick();
        check("fl_wen",   32'(reg_write_en), 32'd0);
        check("fl_fwd",   32'(fwd_valid),    32'd0);
        check("fl_cnt",   32'(retire_count), 32'd7);

        // Capture after flush; bubble not counted
        flush = 1'b0;
        drive(1'b1, 1'b1, 5'd8, WB_RSVD, LD_LW, 2'd0, 32'h00000011, 32'd0, 32'h00000099);
        tick();
        check("rsv_data", write_data,        32'h00000011);
        check("rsv_wen",  32'(reg_write_en), 32'd1);
        check("rsv_cnt",  32'(retire_count), 32'd7);

        // Flush and stall together: bubble loaded, resident retires
        flush = 1'b1;
        stall = 1'b1;
        tick();
        check("fs_wen",   32'(reg_write_en), 32'd0);
        check("fs_cnt",   32'(retire_count), 32'd8);
        flush = 1'b0;
        stall = 1'b0;
        drive(1'b1, 1'b1, 5'd3, WB_ALU, LD_LW, 2'd0, 32'h00000033, 32'd0, 32'd0);
        tick();
        check("fs_cnt2",  32'(retire_count), 32'd8);
        check("fs_wen2",  32'(reg_write_en), 32'd1);

        // Asynchronous reset mid-stall, away from any clock edge
        stall = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        check("ar_wen",   32'(reg_write_en), 32'd0);
        check("ar_cnt",   32'(retire_count), 32'd0);
        check("ar_data",  write_data,        32'd0);
        tick();
        reset = 1'b1;
        stall = 1'b0;

        // Counter wrap: 17 retirements with a 4-bit counter
        drive(1'b1, 1'b1, 5'd1, WB_ALU, LD_LW, 2'd0, 32'h00000001, 32'd0, 32'd0);
        for (int i = 0; i < 17; i++) begin
            tick();
        end
        check("wr_cnt16", 32'(retire_count), 32'd0);
        drive(1'b0, 1'b0, 5'd0, WB_ALU, LD_LW, 2'd0, 32'd0, 32'd0, 32'd0);
        tick();
        check("wr_cnt17", 32'(retire_count), 32'd1);
        tick();
        check("wr_hold",  32'(retire_count), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- MEM/WB pipeline register plus writeback logic for the 5-stage MIPS32 core.
- Captures the memory-stage result, selects ALU, load or link data, and performs big-endian sub-word load extraction with sign/zero extension.
- Drives the register-file write port (enable, destination, data), so it is the writer side of the register file.
- Also supplies the forwarding source for the hazard unit and keeps a retired-instruction counter.

Parameters:
- DATA_W, 32, datapath width.
- CNT_W, 32, retire counter width.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- stall  in  1  hold the current stage contents
- flush  in  1  replace the incoming instruction with a bubble
- in_valid  in  1  incoming instruction is valid
- in_reg_write  in  1  incoming instruction writes a GPR
- in_dest  in  5  destination register number
- in_wb_sel  in  2  result source: 00 ALU, 01 MEM, 10 LINK, 11 reserved (treated as ALU)
- in_load_type  in  3  000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, 101-111 reserved
- in_addr_lo  in  2  effective address bits [1:0]
- in_alu_result  in  DATA_W  ALU result
- in_mem_data  in  DATA_W  raw aligned memory word
- in_pc_plus8  in  DATA_W  link address
- reg_write_en  out  1  register-file write enable
- wb_dest  out  5  register-file write address
- write_data  out  DATA_W  register-file write data
- fwd_valid  out  1  wb_dest/write_data are a valid forwarding source
- addr_err  out  1  misaligned or reserved load is resident
- retire_count  out  CNT_W  count of retired instructions

Behaviour:
- Reset (asynchronous, active-low): all stage registers clear.
  - valid = 0, retire_count = 0, so every output reads 0.
- Posedge with reset high, priority order:
  - flush: stage loads a bubble (valid = 0, other fields don't-care).
  - else stall: stage holds; outputs are stable.
  - else: stage captures all in_* fields.
- Retire:
  - At any posedge where flush or !stall, and the resident entry is valid and not addr_err, retire_count increments by 1.
  - The counter wraps modulo 2^CNT_W.
  - flush and stall together: flush wins, and the resident entry still retires.
- Latency: outputs are combinational from the stage registers, so they appear the cycle after capture.
  - Under stall they persist for multiple cycles; repeated writes of identical data are permitted.
- Load extraction is big-endian; byte 0 is bits [31:24].
  - LB/LBU: select byte addr_lo; LB sign-extends, LBU zero-extends.
  - LH/LHU: addr_lo[1]=0 selects [31:16], addr_lo[1]=1 selects [15:0]; LH sign-extends, LHU zero-extends.
  - LW: full word.
- addr_err = valid & wb_sel==MEM & (LW with addr_lo!=0, or LH/LHU with addr_lo[0]=1, or reserved load_type).
  - addr_err is level, held while the entry is resident.
- write_data: ALU gives alu_result; MEM gives the extracted value; LINK gives pc_plus8.
- reg_write_en = valid & reg_write & (dest != 0) & !addr_err.
  - A write to $0 is never issued.
- fwd_valid = reg_write_en.
- wb_dest = registered dest, driven even when the enable is low.
- Reset mid-stall or mid-flush: reset dominates immediately and asynchronously.

Decomposition:
- Shared package/include (mips_defs):
  - WB_SEL encodings (ALU/MEM/LINK).
  - LOAD_TYPE encodings.
  - Register-number width.
- Natural sub-module: load_extract, purely combinational.
  - Inputs: mem_data, addr_lo, load_type.
  - Outputs: data, err.
  - Reused later by the cache refill path.

Test Plan:
- Reset: hold reset=0 with random inputs -> reg_write_en=0, retire_count=0; release, apply one ALU write (dest=5, alu=0x12345678) -> next cycle reg_write_en=1, wb_dest=5, write_data=0x12345678; following edge retire_count=1.
- Loads: mem_data=0x80FF7F01 -> LB addr_lo=0 gives 0xFFFFFF80; LBU addr_lo=1 gives 0x000000FF; LH addr_lo=2 gives 0x00007F01; LHU addr_lo=0 gives 0x000080FF.
- Errors: LW addr_lo=2 and LH addr_lo=1 -> addr_err=1, reg_write_en=0, retire_count unchanged.
- $0 suppression and link: dest=0 with reg_write=1 -> reg_write_en=0 but the instruction is counted; LINK dest=31, pc_plus8=0x00400010 -> write_data=0x00400010.
- Stall/flush: stall 3 cycles -> outputs constant, no count increments; flush with new input -> next cycle valid=0 and the old entry counted once; flush+stall together -> bubble loaded.
- Counter wrap: with CNT_W=4, retire 17 instructions -> retire_count=1.
